// File: rtl/four_bit_seq_divider.sv
// ---------------------------------------------------------------------------
// four_bit_seq_divider
//
// Unsigned restoring divider that resolves one quotient bit per clock.
// A division takes WIDTH CALC cycles; a zero divisor is answered at once
// (quotient all-ones, remainder = dividend, div_by_zero set).
//
// Handshake: start is a request sampled on every rising edge. It is
// accepted only while the FSM is IDLE or DONE (busy low). There is no
// back-pressure on the result side: done is a one-cycle pulse marking the
// cycle in which quotient/remainder/div_by_zero carry a new result, and
// those outputs then hold until the next result is produced.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   start        in   begin a division (ignored while busy)
//   input_x      in   [WIDTH-1:0] dividend, captured on acceptance
//   input_y      in   [WIDTH-1:0] divisor,  captured on acceptance
//   quotient     out  [WIDTH-1:0] registered quotient
//   remainder    out  [WIDTH-1:0] registered remainder
//   busy         out  high exactly while the FSM is in CALC
//   done         out  one-cycle pulse when a new result is presented
//   div_by_zero  out  high if the last accepted divisor was zero
//   state_dbg    out  [1:0] current FSM state (IDLE=0, CALC=1, DONE=2)
// ---------------------------------------------------------------------------
module four_bit_seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] input_x,
  input  logic [WIDTH-1:0] input_y,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [1:0]       state_dbg
);

  // Counter must be able to hold the value WIDTH itself.
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    step_cnt;
  logic [WIDTH-1:0] x_reg;    // dividend, shifted left so its MSB feeds the next step
  logic [WIDTH-1:0] y_reg;    // divisor held for the whole operation
  logic [WIDTH:0]   rem_reg;  // partial remainder, one bit wider than operands
  logic [WIDTH-1:0] q_reg;    // quotient bits collected so far

  // One restoring step, computed combinationally from the current registers.
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH+1:0] trial_sum;
  logic             no_borrow;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    rem_shift = '0;
    trial_sum = '0;
    no_borrow = 1'b0;
    rem_next  = '0;
    q_next    = '0;

    // Shift in the next dividend bit, MSB first.
    rem_shift = {rem_reg[WIDTH-1:0], x_reg[WIDTH-1]};
    // rem_shift - y as rem_shift + ~y + 1 over WIDTH+1 bits; the extra top
    // bit of trial_sum is the carry out, which is 1 when there is no borrow.
    trial_sum = {1'b0, rem_shift} + {1'b0, ~{1'b0, y_reg}} + (WIDTH + 2)'(1);
    no_borrow = trial_sum[WIDTH+1];
    // Restore on borrow by simply keeping the shifted value.
    rem_next  = no_borrow ? trial_sum[WIDTH:0] : rem_shift;
    q_next    = {q_reg[WIDTH-2:0], no_borrow};
  end

  // The top remainder bit is always zero once a step has settled (the
  // remainder never reaches the divisor); it exists so the shifted value
  // can never overflow before the subtraction.
  logic unused_rem_msb;
  assign unused_rem_msb = rem_reg[WIDTH] ^ rem_next[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      step_cnt    <= '0;
      x_reg       <= '0;
      y_reg       <= '0;
      rem_reg     <= '0;
      q_reg       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            x_reg       <= input_x;
            y_reg       <= input_y;
            rem_reg     <= '0;
            q_reg       <= '0;
            div_by_zero <= 1'b0;
            if (input_y == '0) begin
              // Answer immediately; no CALC cycles.
              state       <= S_DONE;
              step_cnt    <= '0;
              busy        <= 1'b0;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= input_x;
              div_by_zero <= 1'b1;
            end else begin
              state    <= S_CALC;
              step_cnt <= CW'(WIDTH);
              busy     <= 1'b1;
            end
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        S_CALC: begin
          // start is deliberately not looked at here.
          rem_reg  <= rem_next;
          q_reg    <= q_next;
          x_reg    <= {x_reg[WIDTH-2:0], 1'b0};
          step_cnt <= step_cnt - CW'(1);
          if (step_cnt == CW'(1)) begin
            // Last step: publish the result on the same edge.
            state     <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_next;
            remainder <= rem_next[WIDTH-1:0];
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_four_bit_seq_divider.sv
module tb_four_bit_seq_divider;
  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] input_x = '0;
  logic [W-1:0] input_y = '0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  four_bit_seq_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .input_x    (input_x),
    .input_y    (input_y),
    .quotient   (quotient),
    .remainder  (remainder),
    .busy       (busy),
    .done       (done),
    .div_by_zero(div_by_zero),
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [2*W:0] exp_q[$];   // {quotient, remainder, div_by_zero}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division, with the zero-divisor rule.
  function automatic logic [2*W:0] ref_div(input logic [W-1:0] x, input logic [W-1:0] y);
    int unsigned xi, yi;
    xi = x;
    yi = y;
    if (yi == 0) return {{W{1'b1}}, x, 1'b1};
    return {W'(xi / yi), W'(xi % yi), 1'b0};
  endfunction

  // ---------------- monitor ----------------
  logic [2*W:0] mon_e;
  logic [W-1:0] prev_q = '0;
  logic [W-1:0] prev_r = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 with nothing outstanding at %0t", $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("result", {quotient, remainder, div_by_zero}, mon_e);
        end
      end
      if (busy) begin
        check("hold_quotient", quotient, prev_q);
        check("hold_remainder", remainder, prev_r);
      end
    end
    prev_q = quotient;
    prev_r = remainder;
  end

  // ---------------- driver ----------------
  // b2b:   raise start in the current cycle (caller is already at a negedge)
  // poke:  pulse start with junk operands during CALC
  // abort: pull rst_n low in the second CALC cycle
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y,
                       input bit b2b, input bit poke, input bit abort);
    int  k;
    int  busy_cnt;
    bit  seen;
    if (!b2b) @(negedge clk);
    input_x = x;
    input_y = y;
    start   = 1'b1;
    exp_q.push_back(ref_div(x, y));
    @(posedge clk);
    #1;
    start   = 1'b0;
    input_x = W'($urandom);
    input_y = W'($urandom);
    k = 0;
    busy_cnt = 0;
    seen = 1'b0;
    while (!seen && k < 20) begin
      @(negedge clk);
      k++;
      if (abort && k == 2) begin
        rst_n = 1'b0;
        #1;
        check("abort_quotient", quotient, 0);
        check("abort_remainder", remainder, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_dbz", div_by_zero, 0);
        void'(exp_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
          @(negedge clk);
          check("no_done_after_abort", done, 0);
        end
        return;
      end
      if (poke && k == 2) begin
        start   = 1'b1;
        input_x = W'($urandom);
        input_y = W'($urandom);
      end
      if (poke && k == 3) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    check("latency", seen ? k : 99, (y == 0) ? 1 : W + 1);
    check("busy_cycles", busy_cnt, (y == 0) ? 0 : W);
    if (!seen) void'(exp_q.pop_back());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // First edge after reset release accepts the request.
    do_op(4'd13, 4'd4, 1'b1, 1'b0, 1'b0);

    do_op(4'd15, 4'd1,  1'b0, 1'b0, 1'b0);
    do_op(4'd2,  4'd9,  1'b0, 1'b0, 1'b0);
    do_op(4'd15, 4'd15, 1'b0, 1'b0, 1'b0);
    do_op(4'd0,  4'd5,  1'b0, 1'b0, 1'b0);
    do_op(4'd7,  4'd0,  1'b0, 1'b0, 1'b0);

    // Ignored start during CALC, then back-to-back from DONE.
    do_op(4'd13, 4'd4, 1'b0, 1'b1, 1'b0);
    do_op(4'd9,  4'd2, 1'b1, 1'b0, 1'b0);

    // Reset mid-operation, then a clean division.
    do_op(4'd13, 4'd4, 1'b0, 1'b0, 1'b1);
    do_op(4'd6,  4'd3, 1'b0, 1'b0, 1'b0);

    // Every operand pair, with random back-to-back and ignored pokes.
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        do_op(W'(x), W'(y), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0), 1'b0);
      end
    end

    // Random mix including occasional aborts.
    for (int i = 0; i < 60; i++) begin
      do_op(W'($urandom), W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
    end

    repeat (5) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/four_bit_seq_divider.md
FOUR_BIT_SEQ_DIVIDER -- requirements
Module: four_bit_seq_divider

Interface
REQ-001 Parameter: WIDTH, default 4, operand and result width in bits; legal values are 2 to 16.
REQ-002 Port: clk  input  1  single clock; all state updates occur on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request to begin a division; sampled on the rising edge of clk.
REQ-005 Port: input_x  input  WIDTH  dividend, unsigned; sampled when start is accepted.
REQ-006 Port: input_y  input  WIDTH  divisor, unsigned; sampled when start is accepted.
REQ-007 Port: quotient  output  WIDTH  result quotient, registered.
REQ-008 Port: remainder  output  WIDTH  result remainder, registered.
REQ-009 Port: busy  output  1  high while a division is in progress.
REQ-010 Port: done  output  1  one-cycle pulse; high in the cycle when new results are valid.
REQ-011 Port: div_by_zero  output  1  registered flag; high if the last accepted divisor was 0.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-013 start SHALL be accepted only when the state is IDLE or DONE; start in CALC SHALL be ignored.
REQ-014 On acceptance, the block SHALL latch input_x and input_y and clear div_by_zero.
REQ-015 On acceptance with a nonzero divisor, the next state SHALL be CALC and the step counter SHALL be loaded with WIDTH.
REQ-016 On acceptance with input_y == 0, the next state SHALL be DONE with quotient = all-ones, remainder = input_x and div_by_zero = 1; no CALC cycles occur.
REQ-017 Each CALC cycle SHALL perform one restoring step, MSB of the dividend first:
  - shift the partial remainder left one bit, inserting the next dividend bit;
  - compute a (WIDTH+1)-bit trial difference by two's-complement subtraction (add the inverted divisor with carry-in 1);
  - if there is no borrow, keep the difference and set the quotient bit to 1;
  - if there is a borrow, restore the previous value and set the quotient bit to 0.
REQ-018 The partial remainder SHALL be WIDTH+1 bits wide internally, so that no step can overflow.
REQ-019 After the WIDTH-th CALC step, the state SHALL move to DONE, and quotient and remainder SHALL be updated on that same edge.
REQ-020 Latency: with start accepted at edge E0, done SHALL be high during the cycle that follows edge E(WIDTH) (E4 when WIDTH = 4), and SHALL be high for exactly one cycle.
REQ-021 For divide-by-zero, done SHALL be high during the cycle that follows E0.
REQ-022 busy SHALL be high exactly while the state is CALC; it SHALL be low in IDLE and in DONE.
REQ-023 From DONE, the next state SHALL be CALC (or DONE again for divide-by-zero) if start is high; otherwise it SHALL be IDLE.
REQ-024 Back-to-back operation SHALL be supported with no idle cycle between operations.
REQ-025 quotient, remainder and div_by_zero SHALL hold their values until the next operation completes, and SHALL not change while in CALC.
REQ-026 Results SHALL satisfy input_x == quotient*input_y + remainder and remainder < input_y for every nonzero divisor.
REQ-027 Changes on input_x or input_y after acceptance SHALL not affect the operation in progress.

Reset
REQ-028 While rst_n is low, the block SHALL immediately force:
  - state = IDLE;
  - quotient, remainder, busy, done and div_by_zero = 0;
  - the step counter and internal operand registers = 0.
REQ-029 Asserting rst_n mid-operation SHALL abort the operation with no done pulse.
REQ-030 The first start is accepted on the first rising edge after rst_n deasserts.

Verification
REQ-031 start with input_x=13 and input_y=4 -> after 4 cycles of busy, a done pulse with quotient=3, remainder=1 and div_by_zero=0.
REQ-032 Boundary cases:
  - 15/1 -> q=15, r=0;
  - 2/9 -> q=0, r=2;
  - 15/15 -> q=1, r=0;
  - 0/5 -> q=0, r=0.
REQ-033 start with input_x=7 and input_y=0 -> done one cycle after acceptance, quotient=4'hF, remainder=7, div_by_zero=1 and busy never high.
REQ-034 start pulsed again during CALC with different operands -> the pulse is ignored and the first result is delivered; then start held high in DONE with 9/2 -> the next done delivers q=4, r=1 with no IDLE cycle between.
REQ-035 rst_n driven low in the second CALC cycle -> outputs are 0 immediately, no done pulse occurs, and a following 6/3 returns q=2, r=0.
REQ-036 Exhaustive check of all 256 (x,y) pairs at WIDTH=4 against a reference model, including divide-by-zero rules.
